// File: rtl/serial_addsub_8bit.sv
// rtl/serial_addsub_8bit.sv - bit-serial 8-bit adder/subtractor, LSB first, one bit per clock
module serial_addsub_8bit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_x,
    input  logic [7:0] i_y,
    input  logic       i_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_data_out,
    output logic       o_cnext,
    output logic       o_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_sel;
    logic       r_carry;
    logic [2:0] r_cnt;
    logic [7:0] r_res;
    logic       r_c7;
    logic [7:0] r_data_out;
    logic       r_cnext;
    logic       r_ovf;

    logic       w_b_bit;
    logic       w_sum;
    logic       w_cout;
    logic       w_last;

    // Subtract inverts B per bit; the +1 comes from the carry flop preset to SEL.
    assign w_b_bit = r_b[0] ^ r_sel;
    assign w_sum   = r_a[0] ^ w_b_bit ^ r_carry;
    assign w_cout  = (r_a[0] & w_b_bit) | (r_a[0] & r_carry) | (w_b_bit & r_carry);
    assign w_last  = (r_cnt == 3'd7);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_state_next = ST_DONE;
            ST_DONE:               w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a        <= 8'h00;
            r_b        <= 8'h00;
            r_sel      <= 1'b0;
            r_carry    <= 1'b0;
            r_cnt      <= 3'd0;
            r_res      <= 8'h00;
            r_c7       <= 1'b0;
            r_data_out <= 8'h00;
            r_cnext    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_x;
                        r_b     <= i_y;
                        r_sel   <= i_sel;
                        r_carry <= i_sel;
                        r_cnt   <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    r_res   <= {w_sum, r_res[7:1]};
                    r_a     <= {1'b0, r_a[7:1]};
                    r_b     <= {1'b0, r_b[7:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 3'd1;
                    if (w_last) begin
                        // r_carry is the carry into bit 7 while bit 7 is being summed.
                        r_c7       <= r_carry;
                        r_data_out <= {w_sum, r_res[7:1]};
                        r_cnext    <= w_cout;
                        r_ovf      <= r_carry ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state == ST_SHIFT);
    assign o_done     = (r_state == ST_DONE);
    assign o_data_out = r_data_out;
    assign o_cnext    = r_cnext;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_serial_addsub_8bit.sv
// tb/tb_serial_addsub_8bit.sv - scoreboard bench for serial_addsub_8bit with directed vectors
module tb_serial_addsub_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       sel;
    logic       busy;
    logic       done;
    logic [7:0] data_out;
    logic       cnext;
    logic       ovf;

    typedef struct packed {
        logic [7:0] data;
        logic       c;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    logic [7:0] last_data = 8'h00;

    serial_addsub_8bit dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_x        (x),
        .i_y        (y),
        .i_sel      (sel),
        .o_busy     (busy),
        .o_done     (done),
        .o_data_out (data_out),
        .o_cnext    (cnext),
        .o_ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every DONE pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            check("busy_and_done_together", 1, 0);
        end
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out", int'(data_out), int'(e.data));
                check("cnext", int'(cnext), int'(e.c));
                check("ovf", int'(ovf), int'(e.o));
                last_data = e.data;
            end
        end
    end

    // Called at the negedge of cycle N+1; measures latency and optionally disturbs inputs.
    task automatic wait_done(input bit disturb);
        int cyc;
        int nb;
        cyc = 1;
        nb  = 0;
        while (!done && cyc < 20) begin
            if (busy) nb++;
            if (cyc == 4) check("data_out_held_while_busy", int'(data_out), int'(last_data));
            if (disturb && cyc == 3) begin
                start = 1'b1; x = 8'h11; y = 8'h22; sel = ~sel;
            end
            if (disturb && cyc == 6) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("done_cycle", cyc, 9);
        check("busy_cycles", nb, 8);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
    endtask

    task automatic run_op(input logic [7:0] ix, input logic [7:0] iy, input logic isel,
                          input logic [7:0] ed, input logic ec, input logic eo, input bit disturb);
        int d0;
        @(negedge clk);
        x = ix; y = iy; sel = isel; start = 1'b1;
        exp_q.push_back('{data: ed, c: ec, o: eo});
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        wait_done(disturb);
        repeat (2) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        check("idle_after_done", int'(busy), 0);
        check("result_held_idle", int'(data_out), int'(ed));
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; x = 8'h00; y = 8'h00; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_cnext", int'(cnext), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h11, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        run_op(8'h11, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op(8'hAA, 8'h55, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        // START re-asserted with other operands while busy must be ignored.
        run_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Reset in the 4th busy cycle aborts the operation.
        @(negedge clk);
        x = 8'hFF; y = 8'h01; sel = 1'b0; start = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_data", int'(data_out), 0);
        check("abort_cnext", int'(cnext), 0);
        check("abort_ovf", int'(ovf), 0);
        last_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);
        run_op(8'h11, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);

        // START held high across reset release is taken on the first clock.
        @(negedge clk);
        rst_n = 1'b0;
        x = 8'hAA; y = 8'h55; sel = 1'b1; start = 1'b1;
        last_data = 8'h00;
        exp_q.push_back('{data: 8'h55, c: 1'b1, o: 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_through_reset", int'(busy), 1);
        wait_done(1'b0);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub_8bit.md
SERIAL_ADDSUB_8BIT -- requirements
Module: serial_addsub_8bit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 X  input  8  first operand; captured on an accepted START.
REQ-006 Y  input  8  second operand; captured on an accepted START.
REQ-007 SEL  input  1  0 = add X+Y, 1 = subtract X-Y; captured on an accepted START.
REQ-008 BUSY  output  1  high while bits are being processed.
REQ-009 DONE  output  1  one-cycle pulse when the result is valid.
REQ-010 DATA_OUT  output  8  result, held from DONE until the next DONE.
REQ-011 Cnext  output  1  carry out of bit 7: carry for add, 1 = no borrow for subtract.
REQ-012 OVF  output  1  two's-complement signed overflow of the result.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE with START=1 at a rising edge: SHALL load X into operand register A and Y into operand register B.
REQ-015 On that load, SHALL latch SEL, set the carry flop to SEL, and clear the 3-bit counter.
REQ-016 After the load, SHALL enter SHIFT.
REQ-017 Subtract SHALL use B inverted per bit with carry-in 1, i.e. X + ~Y + 1.
REQ-018 SHIFT: each cycle SHALL compute one full-adder bit, LSB first, from A[0], B[0]^SEL and the carry flop.
REQ-019 SHIFT: each cycle SHALL shift the sum bit into the MSB of the result shift register and shift A and B right by one.
REQ-020 SHIFT: each cycle SHALL update the carry flop and increment the counter.
REQ-021 SHIFT: SHALL record the carry into bit 7 on the 8th bit (counter = 7).
REQ-022 On the edge ending the 8th SHIFT cycle (counter = 7), SHALL go to DONE.
REQ-023 On that same edge, SHALL update DATA_OUT with the full result and Cnext with the final carry.
REQ-024 On that same edge, SHALL set OVF = carry-into-bit-7 XOR carry-out; the counter wraps to 0.
REQ-025 DONE: DONE=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-026 Latency: START accepted at edge N -> BUSY high for cycles N+1..N+8 -> DONE high in cycle N+9.
REQ-027 Minimum START-to-START spacing is 10 cycles.
REQ-028 BUSY=1 only in SHIFT; DONE=1 only in DONE state; the two are never high together.
REQ-029 START while in SHIFT or DONE SHALL be ignored (no queuing); X/Y/SEL changes during SHIFT SHALL NOT affect the result.
REQ-030 DATA_OUT, Cnext and OVF SHALL change only on the edge entering DONE; they hold otherwise, including in IDLE.
REQ-031 Arithmetic is modulo 2^8; no saturation.

Reset
REQ-032 RESET_N low SHALL immediately force IDLE, regardless of clock.
REQ-033 Reset values: BUSY=0, DONE=0, DATA_OUT=8'h00, Cnext=0, OVF=0; internal registers and counter = 0.
REQ-034 Reset mid-operation SHALL abort with no DONE pulse; the first START after RESET_N rises SHALL be accepted normally.
REQ-035 START held high through reset release SHALL be accepted on the first rising edge with RESET_N high.

Verification
REQ-036 Add: X=8'h11, Y=8'h11, SEL=0, START pulse -> DONE in 9th cycle; DATA_OUT=8'h22, Cnext=0, OVF=0.
REQ-037 Subtract: X=8'h11, Y=8'h11, SEL=1 -> DATA_OUT=8'h00, Cnext=1, OVF=0.
REQ-038 X=8'hAA, Y=8'h55: SEL=0 -> 8'hFF, Cnext=0, OVF=0; SEL=1 -> 8'h55, Cnext=1, OVF=1.
REQ-039 X=8'hFF, Y=8'h01: SEL=0 -> 8'h00, Cnext=1, OVF=0; SEL=1 -> 8'hFE, Cnext=1, OVF=0.
REQ-040 START re-asserted with new operands during BUSY -> ignored; result matches the original operands; exactly one DONE.
REQ-041 RESET_N pulsed low at the 4th BUSY cycle -> outputs at reset values at once, no DONE; a next operation 8'h11+8'h11 gives 8'h22.
